// File: rtl/mem_access_master.sv
// mem_access_master
// Initiator side of the data-memory interface. Takes one load/store request at a
// time over a valid/ready handshake. It presents the address and data for one
// SETUP cycle, then holds a single read or write strobe for WAIT_CYCLES cycles.
// It returns the result over a second valid/ready handshake. Requests that are
// misaligned or outside the implemented words skip memory entirely.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_write_i             1 = store, 0 = load
//   req_addr_i              byte address
//   req_wdata_i             store data
//   resp_valid_o/resp_ready_i response handshake
//   resp_rdata_o            last load data (kept across stores and errors)
//   resp_err_o              request rejected
//   mem_memwrite_o/mem_memread_o  memory strobes
//   mem_adress_o            memory word address
//   mem_datain_o            memory write data
//   mem_dataout_i           memory read data (combinational)
module mem_access_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_memwrite_o,
  output logic              mem_memread_o,
  output logic [ADDR_W-1:0] mem_adress_o,
  output logic [DATA_W-1:0] mem_datain_o,
  input  logic [DATA_W-1:0] mem_dataout_i
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                addr_err;

  assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          // Address/data are captured even for rejected requests; no strobe follows.
          write_d = req_write_i;
          addr_d  = req_addr_i[ADDR_W+1:2];
          wdata_d = req_wdata_i;
          err_d   = addr_err;
          state_d = addr_err ? RESP : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!write_q) rdata_d = mem_dataout_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register directly so reset drops the strobes at once.
  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = (state_q == RESP);
  assign resp_err_o     = (state_q == RESP) && err_q;
  assign resp_rdata_o   = rdata_q;
  assign mem_memwrite_o = (state_q == ACCESS) && write_q;
  assign mem_memread_o  = (state_q == ACCESS) && !write_q;
  assign mem_adress_o   = addr_q;
  assign mem_datain_o   = wdata_q;

endmodule
